// File: rtl/team_09_wb_master.sv
// Wishbone B4 classic single-transfer bus master for team_09 user logic.
// One request in flight at a time; a programmable timeout guarantees a response.
module team_09_wb_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          TO_ENABLED = (TIMEOUT_CYCLES != 0);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        w_timeout;

  // Timeout fires on the last allowed wait cycle; ACK_I is checked first so it wins a tie.
  assign w_timeout = TO_ENABLED && (r_cnt == TO_LAST);

  // NOTE: req_ready/busy decode from state alone, so no requester input reaches them combinationally.
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state == BUS);

  // NOTE: all state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      WE_O      <= 1'b0;
      STB_O     <= 1'b0;
      CYC_O     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            ADR_O   <= req_adr;
            DAT_O   <= req_dat;
            SEL_O   <= req_sel;
            WE_O    <= req_we;
            r_cnt   <= '0;
            CYC_O   <= 1'b1;
            STB_O   <= 1'b1;
            r_state <= BUS;
          end
        end
        BUS: begin
          if (ACK_I) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_dat   <= WE_O ? 32'd0 : DAT_I;
            r_state   <= IDLE;
          end else if (w_timeout) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_dat   <= 32'd0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_09_wb_master.sv
// Self-checking bench for team_09_wb_master: scripted Wishbone slave plus a
// response scoreboard filled when each request is driven.
module tb_team_09_wb_master;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        nrst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic [3:0]  SEL_O;
  logic        WE_O, STB_O, CYC_O, ACK_I;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;

  team_09_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
    .STB_O(STB_O), .CYC_O(CYC_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (nrst === 1'b1 && rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_dat", rsp_dat, e.dat);
      end
    end
  end

  // One transfer: ack_at = BUS cycle (1-based) on which the slave acks, 0 = never.
  // hold keeps req_valid high with junk fields during BUS to prove they are ignored.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                      input int exp_cycles, input logic exp_err, input bit hold);
    int   cyc_cnt;
    rsp_t e;
    cyc_cnt   = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
    e.err     = exp_err;
    e.dat     = (exp_err || we) ? 32'd0 : rdata;
    sb.push_back(e);
    tick();
    req_valid = hold;
    req_we    = ~we;
    req_adr   = ~adr;
    req_dat   = ~dat;
    req_sel   = ~sel;
    while (CYC_O === 1'b1 && cyc_cnt < 100) begin
      cyc_cnt++;
      check("stb_o", {31'd0, STB_O}, 32'd1);
      check("adr_o", ADR_O, adr);
      check("dat_o", DAT_O, dat);
      check("sel_o", {28'd0, SEL_O}, {28'd0, sel});
      check("we_o", {31'd0, WE_O}, {31'd0, we});
      check("req_ready_bus", {31'd0, req_ready}, 32'd0);
      check("busy_bus", {31'd0, busy}, 32'd1);
      if (cyc_cnt == ack_at) begin
        ACK_I = 1'b1;
        DAT_I = rdata;
      end
      tick();
      ACK_I = 1'b0;
      DAT_I = 32'hBAD0_BAD0;
    end
    check("cyc_len", cyc_cnt, exp_cycles);
    check("cyc_gap", {31'd0, CYC_O}, 32'd0);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
    req_sel = '0; ACK_I = 1'b0; DAT_I = '0;
    tick(); tick();
    check("rst_cyc", {31'd0, CYC_O}, 32'd0);
    check("rst_stb", {31'd0, STB_O}, 32'd0);
    check("rst_we", {31'd0, WE_O}, 32'd0);
    check("rst_adr", ADR_O, 32'd0);
    check("rst_dat_o", DAT_O, 32'd0);
    check("rst_sel", {28'd0, SEL_O}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    nrst = 1'b1;
    tick();

    // Zero-wait write, then a read with three wait states.
    xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1, 32'h5555_AAAA, 1, 1'b0, 1'b0);
    tick();
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 4, 32'h1234_5678, 4, 1'b0, 1'b0);
    tick();
    // Timeout with no ACK, then ACK on the final cycle before expiry.
    xfer(1'b0, 32'h3000_0030, 32'h0, 4'h3, 0, 32'hCAFE_F00D, TO, 1'b1, 1'b0);
    tick();
    xfer(1'b0, 32'h3000_0040, 32'h0, 4'hC, TO, 32'h0BAD_CAFE, TO, 1'b0, 1'b0);
    tick();
    // Timeout on a write, rsp_dat still zero.
    xfer(1'b1, 32'h3000_0044, 32'h1111_2222, 4'h1, 0, 32'h0, TO, 1'b1, 1'b0);
    tick();
    // Back-to-back reads with req_valid held high throughout.
    xfer(1'b0, 32'h4000_0000, 32'h0, 4'hF, 1, 32'hA0A0_0001, 1, 1'b0, 1'b1);
    xfer(1'b0, 32'h4000_0004, 32'h0, 4'hF, 2, 32'hA0A0_0002, 2, 1'b0, 1'b1);
    xfer(1'b0, 32'h4000_0008, 32'h0, 4'hF, 3, 32'hA0A0_0003, 3, 1'b0, 1'b1);
    tick();
    check("b2b_idle", {31'd0, CYC_O}, 32'd0);

    // Reset during a wait state, then a stray ACK in IDLE.
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h5000_0000; req_sel = 4'hF;
    tick();
    req_valid = 1'b0;
    check("abort_cyc_up", {31'd0, CYC_O}, 32'd1);
    tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("abort_cyc", {31'd0, CYC_O}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    ACK_I = 1'b1; DAT_I = 32'hFFFF_0000;
    tick();
    ACK_I = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stray_cyc", {31'd0, CYC_O}, 32'd0);
      check("stray_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end

    check("rsp_count", n_rsp, 8);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
